// File: rtl/prog_countdown_timer.sv
// Run-time programmable countdown timer with prescaler, one-shot/periodic mode,
// registered terminal-count strobe and sticky interrupt flag.
module prog_countdown_timer #(
    parameter int unsigned      WIDTH          = 32,
    parameter int unsigned      PRESCALE_WIDTH = 8,
    parameter logic [WIDTH-1:0] DEFAULT_LOAD   = WIDTH'(50_000_000 - 1)
) (
    input  logic                      Clock,
    input  logic                      ResetN,
    input  logic                      Start,
    input  logic                      Stop,
    input  logic                      Enable,
    input  logic [WIDTH-1:0]          LoadValue,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      Periodic,
    input  logic                      IrqClear,
    output logic [WIDTH-1:0]          Count,
    output logic                      Running,
    output logic                      Pulse,
    output logic                      Irq
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                    state;
    logic [WIDTH-1:0]          reload;
    logic [PRESCALE_WIDTH-1:0] pre_max;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic                      mode;
    logic                      tick;
    logic                      terminal;

    // A tick only happens on an undisturbed, enabled RUN cycle; Stop/Start suppress it.
    always_comb begin
        tick     = (state == RUN) && !Stop && !Start && Enable && (pre_cnt == pre_max);
        terminal = tick && (Count == '0);
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            Count   <= DEFAULT_LOAD;
            reload  <= DEFAULT_LOAD;
            pre_cnt <= '0;
            pre_max <= '0;
            mode    <= 1'b0;
            Running <= 1'b0;
            Pulse   <= 1'b0;
            Irq     <= 1'b0;
        end else begin
            Pulse <= terminal;
            if (terminal) begin
                Irq <= 1'b1;
            end else if (IrqClear) begin
                Irq <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (Start && !Stop) begin
                        Count   <= LoadValue;
                        reload  <= LoadValue;
                        pre_max <= Prescale;
                        mode    <= Periodic;
                        pre_cnt <= '0;
                        state   <= RUN;
                        Running <= 1'b1;
                    end
                end
                RUN: begin
                    if (Stop) begin
                        state   <= IDLE;
                        Running <= 1'b0;
                    end else if (Start) begin
                        Count   <= LoadValue;
                        reload  <= LoadValue;
                        pre_max <= Prescale;
                        mode    <= Periodic;
                        pre_cnt <= '0;
                    end else if (Enable) begin
                        if (pre_cnt != pre_max) begin
                            pre_cnt <= pre_cnt + 1'b1;
                        end else begin
                            pre_cnt <= '0;
                            if (Count != '0) begin
                                Count <= Count - 1'b1;
                            end else if (mode) begin
                                Count <= reload;
                            end else begin
                                state   <= IDLE;
                                Running <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_countdown_timer.sv
// Self-checking bench: directed scenarios plus random stimulus against an
// arithmetic model (elapsed enabled cycles since Start -> ticks -> Count/Pulse).
module tb_prog_countdown_timer;

    localparam int unsigned W  = 16;
    localparam int unsigned PW = 4;
    localparam logic [W-1:0] DEF = 16'd1000;

    logic          Clock = 1'b0;
    logic          ResetN;
    logic          Start, Stop, Enable, Periodic, IrqClear;
    logic [W-1:0]  LoadValue;
    logic [PW-1:0] Prescale;
    logic [W-1:0]  Count;
    logic          Running, Pulse, Irq;

    int n_checks = 0;
    int n_fail   = 0;

    prog_countdown_timer #(
        .WIDTH          (W),
        .PRESCALE_WIDTH (PW),
        .DEFAULT_LOAD   (DEF)
    ) dut (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .Start     (Start),
        .Stop      (Stop),
        .Enable    (Enable),
        .LoadValue (LoadValue),
        .Prescale  (Prescale),
        .Periodic  (Periodic),
        .IrqClear  (IrqClear),
        .Count     (Count),
        .Running   (Running),
        .Pulse     (Pulse),
        .Irq       (Irq)
    );

    always #5 Clock = ~Clock;

    // Model: n = enabled cycles since Start, P = prescale+1, ticks = n/P.
    bit     m_run;
    longint m_n, m_r, m_p, m_idle_count;
    bit     m_mode, m_irq, m_pulse;
    int     pulse_seen;

    function automatic longint cur_count();
        if (!m_run)      return m_idle_count;
        else if (m_mode) return m_r - ((m_n / m_p) % (m_r + 1));
        else             return m_r - (m_n / m_p);
    endfunction

    task automatic model_reset();
        m_run = 0; m_n = 0; m_r = DEF; m_p = 1; m_mode = 0;
        m_idle_count = DEF; m_irq = 0; m_pulse = 0;
    endtask

    task automatic model_load(input longint lv, input longint ps, input bit per);
        m_run = 1; m_n = 0; m_r = lv; m_p = ps + 1; m_mode = per;
    endtask

    task automatic model_edge(input bit st, input bit sp, input bit en,
                              input longint lv, input longint ps, input bit per, input bit clr);
        bit term = 0;
        if (m_run) begin
            if (sp) begin
                m_idle_count = cur_count();
                m_run = 0;
            end else if (st) begin
                model_load(lv, ps, per);
            end else if (en) begin
                m_n++;
                if ((m_n % m_p) == 0 && ((m_n / m_p) % (m_r + 1)) == 0) begin
                    term = 1;
                    if (!m_mode) begin
                        m_run = 0;
                        m_idle_count = 0;
                    end
                end
            end
        end else if (st && !sp) begin
            model_load(lv, ps, per);
        end
        if (term)     m_irq = 1;
        else if (clr) m_irq = 0;
        m_pulse = term;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count",   longint'(Count),   cur_count());
        check("running", longint'(Running), longint'(m_run));
        check("pulse",   longint'(Pulse),   longint'(m_pulse));
        check("irq",     longint'(Irq),     longint'(m_irq));
    endtask

    task automatic step(input bit st, input bit sp, input bit en, input int lv,
                        input int ps, input bit per, input bit clr);
        Start = st; Stop = sp; Enable = en; LoadValue = W'(lv);
        Prescale = PW'(ps); Periodic = per; IrqClear = clr;
        @(posedge Clock);
        model_edge(st, sp, en, lv, ps, per, clr);
        #1;
        check_all();
        if (Pulse) pulse_seen++;
    endtask

    initial begin
        ResetN = 1'b0; Start = 0; Stop = 0; Enable = 1; Periodic = 0;
        IrqClear = 0; LoadValue = '0; Prescale = '0;
        model_reset();
        #12;
        check_all();
        ResetN = 1'b1;

        // Periodic LoadValue=10, then asynchronous reset mid-count
        step(1, 0, 1, 10, 0, 1, 0);
        repeat (14) step(0, 0, 1, 10, 0, 1, 0);
        check("irq_before_reset", longint'(Irq), 1);
        ResetN = 1'b0;
        #1;
        model_reset();
        check("rst_count",   longint'(Count),   longint'(DEF));
        check("rst_running", longint'(Running), 0);
        check("rst_pulse",   longint'(Pulse),   0);
        check("rst_irq",     longint'(Irq),     0);
        #2 ResetN = 1'b1;

        // Periodic basic: 3,2,1,0,3 and Pulse every 4 edges
        step(1, 0, 1, 3, 0, 1, 0);
        pulse_seen = 0;
        repeat (3) step(0, 0, 1, 3, 0, 1, 0);
        check("periodic_no_early_pulse", pulse_seen, 0);
        step(0, 0, 1, 3, 0, 1, 0);
        check("periodic_first_pulse", longint'(Pulse), 1);
        repeat (8) step(0, 0, 1, 3, 0, 1, 0);
        check("periodic_pulses", pulse_seen, 3);

        // One-shot with prescale: single pulse at edge 6
        step(0, 1, 1, 0, 0, 0, 1);
        step(1, 0, 1, 2, 1, 0, 0);
        pulse_seen = 0;
        repeat (6) step(0, 0, 1, 2, 1, 0, 0);
        check("oneshot_pulse_edge6", longint'(Pulse), 1);
        check("oneshot_running_low", longint'(Running), 0);
        repeat (20) step(0, 0, 1, 2, 1, 0, 0);
        check("oneshot_single_pulse", pulse_seen, 1);
        check("oneshot_count_zero", longint'(Count), 0);

        // Pause: 5 disabled cycles delay the first pulse to edge 13
        step(1, 0, 1, 7, 0, 1, 0);
        pulse_seen = 0;
        repeat (3) step(0, 0, 1, 7, 0, 1, 0);
        repeat (5) step(0, 0, 0, 7, 0, 1, 0);
        repeat (4) step(0, 0, 1, 7, 0, 1, 0);
        check("pause_no_pulse_yet", pulse_seen, 0);
        step(0, 0, 1, 7, 0, 1, 0);
        check("pause_pulse_edge13", longint'(Pulse), 1);
        repeat (8) step(0, 0, 1, 7, 0, 1, 0);
        check("pause_next_period", longint'(Pulse), 1);

        // Priority: Start+Stop -> IDLE frozen; terminal tick beats IrqClear
        step(1, 0, 1, 9, 0, 1, 1);
        repeat (2) step(0, 0, 1, 9, 0, 1, 0);
        step(1, 1, 1, 4, 0, 1, 0);
        check("startstop_idle", longint'(Running), 0);
        check("startstop_frozen", longint'(Count), 7);
        step(1, 0, 1, 3, 0, 1, 1);
        repeat (3) step(0, 0, 1, 3, 0, 1, 1);
        check("irq_cleared_before_tick", longint'(Irq), 0);
        step(0, 0, 1, 3, 0, 1, 1);
        check("irq_set_beats_clear", longint'(Irq), 1);
        step(0, 0, 1, 3, 0, 1, 1);
        check("irq_cleared_after", longint'(Irq), 0);

        // LoadValue=0, Prescale=0 periodic: Pulse continuously high
        step(1, 0, 1, 0, 0, 1, 0);
        pulse_seen = 0;
        repeat (6) step(0, 0, 1, 0, 0, 1, 0);
        check("zero_load_continuous", pulse_seen, 6);
        pulse_seen = 0;
        repeat (6) step(0, 0, 1, 5, 3, 1, 0);
        check("lv_change_ignored", pulse_seen, 6);
        step(1, 0, 1, 5, 0, 1, 0);
        pulse_seen = 0;
        repeat (12) step(0, 0, 1, 5, 0, 1, 0);
        check("period_six", pulse_seen, 2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 3), ($urandom_range(99) < 2),
                 ($urandom_range(99) < 85), int'($urandom_range(12)),
                 int'($urandom_range(3)), 1'($urandom_range(1)),
                 ($urandom_range(99) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_countdown_timer.md
Name: prog_countdown_timer

Overview:
Parametrised, run-time programmable countdown timer. It is the successor to the fixed-value, always-periodic countdown timer. It adds a run-time load value, a prescaler, one-shot/periodic mode, start/stop control, a registered terminal pulse and a sticky interrupt flag with clear. It sits beside the system clock as the general tick/timeout source for display refresh, debounce and timeout logic.

Parameters:
WIDTH, 32, bit width of countdown counter, LoadValue and Count.
PRESCALE_WIDTH, 8, bit width of prescaler compare value.
DEFAULT_LOAD, 50_000_000-1, value Count takes at reset; must fit in WIDTH bits.

Ports:
Clock  input  1  system clock; all state changes on its rising edge.
ResetN  input  1  asynchronous, active-low reset.
Start  input  1  level-sampled; latches LoadValue/Prescale/Periodic and starts or restarts counting.
Stop  input  1  halts counting and returns to IDLE; Count freezes.
Enable  input  1  when low in RUN, the prescaler and Count hold (pause).
LoadValue  input  WIDTH  countdown start value, sampled only on Start.
Prescale  input  PRESCALE_WIDTH  tick divisor minus 1, sampled only on Start.
Periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot. Sampled only on Start.
IrqClear  input  1  clears Irq.
Count  output  WIDTH  current counter value.
Running  output  1  high while in state RUN.
Pulse  output  1  registered one-cycle terminal-count strobe.
Irq  output  1  sticky terminal-count flag.

Behaviour:
- Reset (ResetN=0, asynchronous) sets: state=IDLE, Count=DEFAULT_LOAD, Reload=DEFAULT_LOAD, PreCnt=0, PreMax=0, Mode=0, Running=0, Pulse=0, Irq=0.
- Internal registers: Reload (WIDTH), PreMax (PRESCALE_WIDTH), PreCnt (PRESCALE_WIDTH), Mode (1 bit).
- Two states: IDLE and RUN. Running = (state==RUN).
- Stop has priority over Start in every state.
- IDLE: Count holds.
  - Start=1 and Stop=0: Count<=LoadValue, Reload<=LoadValue, PreMax<=Prescale, Mode<=Periodic, PreCnt<=0, go to RUN.
- RUN:
  - Stop=1: go to IDLE. Count and PreCnt hold. No Pulse.
  - Else Start=1: restart exactly as from IDLE. No Pulse, even if Count==0 that cycle.
  - Else Enable=0: hold everything.
  - Else Enable=1:
    - If PreCnt!=PreMax: PreCnt<=PreCnt+1.
    - If PreCnt==PreMax: PreCnt<=0 and a tick occurs.
- Tick handling:
  - Count!=0: Count<=Count-1.
  - Count==0: Pulse<=1 and Irq<=1 on that edge.
    - Mode=1: Count<=Reload, stay in RUN.
    - Mode=0: Count stays 0, go to IDLE (Running falls on the same edge Pulse rises).
- Pulse is 0 on every edge that is not a terminal tick, so it is exactly one cycle wide. The exception is back-to-back terminal ticks (LoadValue=0, Prescale=0, periodic), where Pulse stays continuously high.
- Period in enabled cycles = (Reload+1)*(PreMax+1).
- First Pulse rises (Reload+1)*(PreMax+1) edges after the Start edge.
- No wrap-around: Count never decrements below 0.
- Irq: set by a terminal tick; cleared by IrqClear=1. If set and clear occur on the same edge, set wins. Irq is independent of state.
- LoadValue and Prescale changes while in RUN have no effect until the next Start.

Test Plan:
1. Reset: run periodic with LoadValue=10, assert ResetN=0 mid-count (between edges) -> Count=DEFAULT_LOAD, Running=0, Pulse=0, Irq=0 immediately, without waiting for a clock edge.
2. Periodic basic: LoadValue=3, Prescale=0, Periodic=1, Start for one cycle -> Count sequence 3,2,1,0,3,...; Pulse high for one cycle 4 edges after Start, then every 4 cycles; Irq=1 from the first Pulse; Running stays 1.
3. One-shot with prescale: LoadValue=2, Prescale=1, Periodic=0 -> single Pulse 6 edges after Start; Running falls on the same edge; Count stays 0; no further Pulse over 20 cycles.
4. Pause: periodic, LoadValue=7, Prescale=0, Enable=0 for 5 cycles mid-count -> Count frozen during the pause; first Pulse at edge 8+5=13 after Start; next period unchanged at 8.
5. Priority: Start=1 and Stop=1 on the same edge in RUN -> IDLE with Count frozen; a terminal tick coinciding with IrqClear=1 -> Irq stays 1; IrqClear on the next edge -> Irq=0.
6. Edge case: LoadValue=0, Prescale=0, Periodic=1 -> Pulse continuously high from edge 1; change LoadValue to 5 without Start -> no effect; assert Start -> period becomes 6.
